// File: rtl/prv32_pkg.sv
// Shared rv32i branch-unit definitions: funct3 encodings, ALU opcode, FSM state type.
package prv32_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Flags consumed here come from a compare-subtract
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} br_state_t;

endpackage

// File: rtl/prv32_branch_cond.sv
// Combinational branch condition decode from funct3 and ALU subtract flags.
module prv32_branch_cond
    import prv32_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       cf,
    input  logic       zf,
    input  logic       vf,
    input  logic       sf,
    output logic       cond,
    output logic       illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zf;
            F3_BNE:  cond = ~zf;
            F3_BLT:  cond = sf ^ vf;
            F3_BGE:  cond = ~(sf ^ vf);
            F3_BLTU: cond = ~cf;   // cf=1 means no borrow
            F3_BGEU: cond = cf;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/prv32_branch_unit.sv
// Branch decision, single fetch redirect and fixed-length pipeline flush.
// Define PRV32_BRANCH_STATS_EN to add br_count / br_taken_count statistics outputs.
module prv32_branch_unit
    import prv32_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [2:0]      ex_funct3,
    input  logic            cf,
    input  logic            zf,
    input  logic            vf,
    input  logic            sf,
    input  logic [XLEN-1:0] ex_target,
    input  logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic            illegal_br
`ifdef PRV32_BRANCH_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     br_taken_count
`endif
);

    // REDIRECT already covers one flush cycle, FLUSH counts down the rest
    localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES >= 2) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    br_state_t  state, state_nxt;
    logic [2:0] cnt;
    logic       cond, illegal, accept, take;

    prv32_branch_cond u_cond (
        .funct3  (ex_funct3),
        .cf      (cf),
        .zf      (zf),
        .vf      (vf),
        .sf      (sf),
        .cond    (cond),
        .illegal (illegal)
    );

    assign accept = ex_valid & ~busy;
    assign take   = accept & (ex_jump | (ex_branch & cond));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (take) state_nxt = REDIRECT;
            REDIRECT: if (~stall) state_nxt = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
            FLUSH:    if (cnt == 3'd0) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = (state == REDIRECT);
        flush          = (state != IDLE);
        busy           = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 3'd0;
        else if (state == REDIRECT && ~stall)
            cnt <= CNT_INIT;
        else if (state == FLUSH && cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc <= '0;
            illegal_br  <= 1'b0;
        end else begin
            if (take) redirect_pc <= ex_target;
            illegal_br <= accept & ex_branch & ~ex_jump & illegal;
        end
    end

`ifdef PRV32_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count       <= 32'd0;
            br_taken_count <= 32'd0;
        end else begin
            if (accept & ex_branch) br_count       <= br_count + 32'd1;
            if (take & ex_branch)   br_taken_count <= br_taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/prv32_branch_unit.md
Name: prv32_branch_unit

Overview:
- Consumer of the ALU flag interface (cf, zf, vf, sf). It turns the flags of a compare-subtract (alufn 4'b0001) into a branch decision.
- Sits after the EX stage of the pipelined rv32i core and owns the front-end redirect and pipeline flush sequence.
- Registers the decision, issues one redirect to the fetch unit, then holds the flush for a fixed number of cycles.

Parameters:
- FLUSH_CYCLES, 2: total cycles flush is asserted per redirect, including the redirect cycle. Legal range 1..7.
- XLEN, 32: width of the PC and target.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_branch  input  1  instruction is a conditional branch
- ex_jump  input  1  instruction is JAL/JALR (unconditional)
- ex_funct3  input  3  branch funct3
- cf  input  1  ALU carry (1 = no borrow, a >= b unsigned)
- zf  input  1  ALU zero
- vf  input  1  ALU overflow
- sf  input  1  ALU sign
- ex_target  input  XLEN  computed branch/jump target
- stall  input  1  fetch cannot accept a redirect this cycle
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  XLEN  new PC
- flush  output  1  kill IF/ID/EX contents
- busy  output  1  FSM not in IDLE
- illegal_br  output  1  one-cycle pulse: branch with funct3 010/011 seen

Behaviour:
- Condition decode (combinational, internal):
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf ^ vf
  - 101 BGE: ~(sf ^ vf)
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010/011: not taken, and illegal_br pulses the next cycle.
- take = ex_valid & ~busy & (ex_jump | (ex_branch & cond)). ex_jump has priority over ex_branch.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE:
  - On take: latch ex_target into redirect_pc and go to REDIRECT.
  - Otherwise stay in IDLE.
  - stall has no effect in IDLE.
- REDIRECT:
  - redirect_valid = 1, flush = 1.
  - The handshake completes on a cycle where redirect_valid & ~stall.
  - While stall = 1: hold in REDIRECT with redirect_pc stable.
  - On completion: if FLUSH_CYCLES == 1, go to IDLE. Otherwise load cnt = FLUSH_CYCLES-2 and go to FLUSH.
- FLUSH:
  - flush = 1, redirect_valid = 0.
  - If cnt == 0, go to IDLE; else decrement cnt.
  - cnt is 3 bits and never wraps.
- busy = (state != IDLE).
- While busy, ex_valid/ex_branch/ex_jump are ignored, because those instructions are being flushed.
- Latency:
  - redirect_valid rises 1 cycle after the EX cycle with take.
  - With no stall, flush stays high for exactly FLUSH_CYCLES consecutive cycles.
- Reset:
  - rst wins over everything, including mid-REDIRECT or mid-FLUSH.
  - On the next edge: state = IDLE, cnt = 0.
  - redirect_valid, redirect_pc, flush, busy and illegal_br are all 0.
- Boundaries:
  - take coincident with the last FLUSH cycle is ignored (busy = 1).
  - An illegal funct3 during busy produces no pulse.
  - redirect_pc is undefined only before the first take; it is forced to 0 by reset.

Optional Feature:
- Macro: PRV32_BRANCH_STATS_EN.
- When defined, the block adds two outputs:
  - br_count (32 bits): increments on every accepted ex_valid & ex_branch in IDLE.
  - br_taken_count (32 bits): increments on every take with ex_branch.
- Both counters wrap at 2^32 and reset to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package prv32_pkg holds:
  - funct3 constants F3_BEQ..F3_BGEU
  - FSM state typedef br_state_t {IDLE, REDIRECT, FLUSH}
  - alufn constant ALU_SUB = 4'b0001
- Sub-module prv32_branch_cond: purely combinational funct3 + flags -> cond/illegal. It is reused by the verification model.

Test Plan:
- BEQ with zf=1, ex_target=0x0000_0040, stall=0 -> redirect_valid=1 with redirect_pc=0x40 next cycle; flush high 2 cycles; busy then returns to 0.
- BLTU with cf=1 (a>=b) -> no redirect, flush=0. BGEU with cf=1 -> redirect taken.
- BLT with sf=1, vf=1 (overflowed subtract, a>=b) -> not taken. BGE with the same flags -> taken.
- Taken branch with stall high for 3 cycles -> redirect_valid and redirect_pc=0x100 held 3 cycles; flush sequence starts after the stall drops.
- funct3=011 with ex_branch=1 -> illegal_br pulses 1 cycle, no redirect. A JAL issued during FLUSH -> ignored.
- rst asserted during FLUSH with FLUSH_CYCLES=4 -> next cycle all outputs 0, state IDLE. With the macro defined, the counters clear.
